ps2_keycode_rx: RTL

- Receives the raw PS/2 keyboard serial stream and produces the 8-bit HID-style `keycode` byte that the pacman movement controller consumes.
- Decodes Set-2 make/break/extended sequences for W/A/S/D and the four arrow keys.
- Holds the code of the most recently pressed key until that key is released.
- Sits between the board PS/2 pins and the game logic, replacing the USB keycode path.

---
 rtl/ps2_keycode_rx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 keyboard receiver: frames bytes off the raw pins and
// tracks the held WASD/arrow key as an 8-bit HID-style keycode.
`timescale 1ns/1ps
module ps2_keycode_rx #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] csync_q, csync_d;
  logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [9:0]             frame_q, frame_d;
  logic                   brk_q, brk_d;
  logic                   ext_q, ext_d;
  logic [7:0]             key_q, key_d;
  logic [7:0]             rx_q, rx_d;
  logic                   kev_q, kev_d;
  logic                   stb_q, stb_d;
  logic                   ferr_q, ferr_d;

  logic       ps2c;
  logic       ps2d;
  logic       fall;
  logic [7:0] code;

  function automatic logic [7:0] map_code(
    input logic       e,
    input logic [7:0] b
  );
    case ({e, b})
      9'h01D:  map_code = 8'h1A;
      9'h01C:  map_code = 8'h04;
      9'h01B:  map_code = 8'h16;
      9'h023:  map_code = 8'h07;
      9'h175:  map_code = 8'h1A;
      9'h16B:  map_code = 8'h04;
      9'h172:  map_code = 8'h16;
      9'h174:  map_code = 8'h07;
      default: map_code = 8'h00;
    endcase
  endfunction

  assign ps2c = csync_q[SYNC_STAGES-1];
  assign ps2d = dsync_q[SYNC_STAGES-1];
  assign fall = clk_prev_q & ~ps2c;
  assign code = map_code(ext_q, frame_q[7:0]);

  assign keycode   = key_q;
  assign key_event = kev_q;
  assign rx_byte   = rx_q;
  assign rx_strobe = stb_q;
  assign frame_err = ferr_q;

  always_comb begin
    csync_d    = {csync_q[SYNC_STAGES-2:0], PS2_CLK};
    dsync_d    = {dsync_q[SYNC_STAGES-2:0], PS2_DATA};
    clk_prev_d = ps2c;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    tcnt_d     = tcnt_q;
    frame_d    = frame_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    key_d      = key_q;
    rx_d       = rx_q;
    kev_d      = 1'b0;
    stb_d      = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tcnt_d   = '0;
        bitcnt_d = '0;
        if (fall) begin
          if (!ps2d) begin
            state_d  = SHIFT;
            bitcnt_d = 4'd1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall) begin
          // LSB first: after ten shifts [7:0]=data, [8]=parity, [9]=stop
          frame_d  = {ps2d, frame_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tcnt_d   = '0;
          if (bitcnt_q == 4'd10) begin
            state_d = CHECK;
          end
        end else if (tcnt_q == TO_LAST) begin
          ferr_d   = 1'b1;
          state_d  = IDLE;
          bitcnt_d = '0;
          tcnt_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d  = IDLE;
        bitcnt_d = '0;
        if (frame_q[9] && (^frame_q[8:0])) begin
          rx_d  = frame_q[7:0];
          stb_d = 1'b1;
          unique case (1'b1)
            (frame_q[7:0] == 8'hE0): ext_d = 1'b1;
            (frame_q[7:0] == 8'hF0): brk_d = 1'b1;
            default: begin
              brk_d = 1'b0;
              ext_d = 1'b0;
              if (code != 8'h00) begin
                if (!brk_q && (key_q != code)) begin
                  key_d = code;
                  kev_d = 1'b1;
                end else if (brk_q && (key_q == code)) begin
                  key_d = 8'h00;
                  kev_d = 1'b1;
                end
              end
            end
          endcase
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      csync_q    <= '1;
      dsync_q    <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      tcnt_q     <= '0;
      frame_q    <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      key_q      <= 8'h00;
      rx_q       <= 8'h00;
      kev_q      <= 1'b0;
      stb_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      csync_q    <= csync_d;
      dsync_q    <= dsync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      tcnt_q     <= tcnt_d;
      frame_q    <= frame_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      key_q      <= key_d;
      rx_q       <= rx_d;
      kev_q      <= kev_d;
      stb_q      <= stb_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule
